// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch resolution slice.
// Control-flow class, resolver FSM states, instruction size.
package rv32i_types;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_BR   = 2'd1,
    CF_JAL  = 2'd2,
    CF_JALR = 2'd3
  } cf_t;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } br_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async low), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: classifies each resolved control-flow
// instruction, holds a PC redirect to fetch (valid/ready) and flushes
// the wrong path, pulses predictor update and misalign flags.
// Inputs: ex_* instruction info, br_en, br_target, jalr_target,
// redir_ready. Outputs: redir_valid/redir_pc, flush, upd_*,
// misalign, perf_br_cnt, perf_mispred_cnt.
// Macro BR_PERF_CNT_EN enables the saturating performance counters;
// without it both counter ports read 0.
module branch_resolve
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  cf_t              ex_cf,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             br_en,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  jalr_target,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             flush,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             misalign,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  br_state_t       state_q, state_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            upd_valid_q;
  logic [XLEN-1:0] upd_pc_q;
  logic            upd_taken_q;
  logic            misalign_q;

  logic            resolve;
  logic            act_taken;
  logic [XLEN-1:0] act_target;
  logic [XLEN-1:0] next_pc;
  logic            mispred;
  logic            misaligned;
  logic            go_redir;

  always_comb begin
    act_taken  = 1'b0;
    act_target = br_target;
    unique case (ex_cf)
      CF_BR:   act_taken = br_en;
      CF_JAL:  act_taken = 1'b1;
      CF_JALR: begin
        act_taken  = 1'b1;
        act_target = jalr_target & ~XLEN'(1);
      end
      default: act_taken = 1'b0;
    endcase
  end

  assign resolve = (state_q == IDLE) && ex_valid
                 && (ex_cf != CF_NONE);

  assign next_pc = act_taken ? act_target
                 : ex_pc + XLEN'(INSTR_BYTES);

  assign mispred = (act_taken != ex_pred_taken)
                || (act_taken && (act_target != ex_pred_target));

  assign misaligned = act_taken && (act_target[1:0] != 2'b00);

  // Misaligned targets go to the trap unit; no redirect from here.
  assign go_redir = resolve && mispred && !misaligned;

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    unique case (state_q)
      IDLE: begin
        if (go_redir) begin
          state_d    = REDIR;
          redir_pc_d = next_pc;
        end
      end
      REDIR: begin
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      redir_pc_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      upd_valid_q <= resolve;
      misalign_q  <= resolve && misaligned;
      if (resolve) begin
        upd_pc_q    <= ex_pc;
        upd_taken_q <= act_taken;
      end
    end
  end

  assign redir_valid = (state_q == REDIR);
  assign flush       = (state_q == REDIR);
  assign redir_pc    = redir_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign misalign    = misalign_q;

`ifdef BR_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve),
    .count (perf_br_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (go_redir),
    .count (perf_mispred_cnt)
  );
`else
  assign perf_br_cnt      = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
// Table vectors plus hand sequences for REDIR hold, wrap, reset, counters.
module tb_branch_resolve;
  import rv32i_types::*;

`ifdef BR_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  cf_t         ex_cf;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        br_en;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        misalign;
  logic [1:0]  perf_br_cnt;
  logic [1:0]  perf_mispred_cnt;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_cf            (ex_cf),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .br_en            (br_en),
    .br_target        (br_target),
    .jalr_target      (jalr_target),
    .redir_valid      (redir_valid),
    .redir_pc         (redir_pc),
    .redir_ready      (redir_ready),
    .flush            (flush),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .misalign         (misalign),
    .perf_br_cnt      (perf_br_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  typedef struct {
    cf_t         cf;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        be;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        e_upd;
    logic        e_tk;
    logic        e_mis;
    logic        e_red;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic drive(input cf_t cf, input logic [31:0] pc,
                       input logic pt, input logic [31:0] ptg,
                       input logic be, input logic [31:0] bt,
                       input logic [31:0] jt);
    ex_cf          = cf;
    ex_pc          = pc;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    br_en          = be;
    br_target      = bt;
    jalr_target    = jt;
    ex_valid       = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    drive(t.cf, t.pc, t.pt, t.ptg, t.be, t.bt, t.jt);
    redir_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    chk({s, " upd_valid"}, 32'(upd_valid), 32'(t.e_upd));
    if (t.e_upd) begin
      chk({s, " upd_pc"}, upd_pc, t.pc);
      chk({s, " upd_taken"}, 32'(upd_taken), 32'(t.e_tk));
    end
    chk({s, " misalign"}, 32'(misalign), 32'(t.e_mis));
    chk({s, " redir_valid"}, 32'(redir_valid), 32'(t.e_red));
    chk({s, " flush"}, 32'(flush), 32'(t.e_red));
    if (t.e_red) begin
      chk({s, " redir_pc"}, redir_pc, t.e_rpc);
      redir_ready = 1'b1;
      tick();
      redir_ready = 1'b0;
      chk({s, " redir drop"}, 32'(redir_valid), 32'd0);
      chk({s, " flush drop"}, 32'(flush), 32'd0);
    end else begin
      tick();
    end
    chk({s, " upd pulse end"}, 32'(upd_valid), 32'd0);
    chk({s, " mis pulse end"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    logic [31:0] hold_pc;
    int          k;
    int          exp_b;
    int          exp_m;

    v[0] = '{CF_BR,   32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    v[1] = '{CF_JALR, 32'h400, 1'b1, 32'h3000, 1'b0, 32'h0, 32'h2001,
             1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
    v[2] = '{CF_JAL,  32'h500, 1'b1, 32'h202, 1'b0, 32'h202, 32'h0,
             1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    v[3] = '{CF_BR,   32'h600, 1'b0, 32'h0, 1'b0, 32'h640, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    v[4] = '{CF_BR,   32'h700, 1'b0, 32'h0, 1'b1, 32'h780, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 32'h780};
    v[5] = '{CF_JAL,  32'h800, 1'b1, 32'h900, 1'b0, 32'h880, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 32'h880};
    v[6] = '{CF_JAL,  32'h900, 1'b0, 32'h0, 1'b0, 32'h903, 32'h0,
             1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    v[7] = '{CF_BR,   32'h200, 1'b1, 32'h1002, 1'b0, 32'h1002, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b1, 32'h204};
    v[8] = '{CF_NONE, 32'hA00, 1'b1, 32'hB00, 1'b1, 32'hB00, 32'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    v[9] = '{CF_JALR, 32'hC00, 1'b1, 32'h4000, 1'b0, 32'h0, 32'h4003,
             1'b1, 1'b1, 1'b1, 1'b0, 32'h0};

    rst_n = 1'b0;
    ex_valid = 1'b0;
    redir_ready = 1'b0;
    drive(CF_NONE, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    ex_valid = 1'b0;
    #12;
    chk("rst redir_valid", 32'(redir_valid), 32'd0);
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst redir_pc", redir_pc, 32'd0);
    chk("rst upd_valid", 32'(upd_valid), 32'd0);
    chk("rst upd_pc", upd_pc, 32'd0);
    chk("rst upd_taken", 32'(upd_taken), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst br_cnt", 32'(perf_br_cnt), 32'd0);
    chk("rst mis_cnt", 32'(perf_mispred_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ready while idle must not disturb anything
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("idle ready redir", 32'(redir_valid), 32'd0);
    chk("idle ready upd", 32'(upd_valid), 32'd0);

    for (int i = 0; i < 10; i++) apply(v[i], i);

    // mispredict held with ready low, wrong-path ex_valid ignored
    drive(CF_BR, 32'h100, 1'b1, 32'h140, 1'b0, 32'h140, 32'h0);
    tick();
    chk("hold enter", 32'(redir_valid), 32'd1);
    chk("hold pc0", redir_pc, 32'h104);
    hold_pc = 32'h104;
    drive(CF_BR, 32'h300, 1'b0, 32'h0, 1'b1, 32'h380, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d valid", c), 32'(redir_valid), 32'd1);
      chk($sformatf("hold%0d flush", c), 32'(flush), 32'd1);
      chk($sformatf("hold%0d pc", c), redir_pc, hold_pc);
      chk($sformatf("hold%0d upd", c), 32'(upd_valid), 32'd0);
    end
    ex_valid = 1'b0;
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("hold exit valid", 32'(redir_valid), 32'd0);
    chk("hold exit upd", 32'(upd_valid), 32'd0);

    // PC wrap then async reset in the middle of REDIR
    drive(CF_BR, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 32'h10, 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("wrap valid", 32'(redir_valid), 32'd1);
    chk("wrap pc", redir_pc, 32'h0);
    chk("wrap upd_pc", upd_pc, 32'hFFFF_FFFC);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(redir_valid), 32'd0);
    chk("midrst flush", 32'(flush), 32'd0);
    chk("midrst br_cnt", 32'(perf_br_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // counters: 5 mispredicts, each with a wrong-path pulse in REDIR
    exp_b = 0;
    exp_m = 0;
    for (k = 1; k <= 5; k++) begin
      drive(CF_BR, 32'h100, 1'b1, 32'h140, 1'b0, 32'h140, 32'h0);
      tick();
      drive(CF_JAL, 32'h800, 1'b0, 32'h0, 1'b0, 32'h880, 32'h0);
      tick();
      ex_valid = 1'b0;
      redir_ready = 1'b1;
      tick();
      redir_ready = 1'b0;
      if (PERF) begin
        exp_b = (k > 3) ? 3 : k;
        exp_m = (k > 3) ? 3 : k;
      end
      chk($sformatf("cnt%0d br", k), 32'(perf_br_cnt), 32'(exp_b));
      chk($sformatf("cnt%0d mis", k), 32'(perf_mispred_cnt),
          32'(exp_m));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
